// File: rtl/hwpe_ctrl_reqrsp_arbiter.sv
// Round-robin arbiter sharing one reqrsp HWPE control slave between N_REQ cores,
// with one access in flight and a PUSH..TRIGGER/SOFTCLR ownership lock.
package hwpe_ctrl_reqrsp_pkg;
    typedef struct packed {
        logic [31:0] q_addr;
        logic        q_write;
        logic [31:0] q_data;
        logic        q_valid;
        logic        p_ready;
    } reqrsp_req_t;

    typedef struct packed {
        logic        q_ready;
        logic [31:0] p_data;
        logic        p_valid;
    } reqrsp_rsp_t;
endpackage

module hwpe_ctrl_reqrsp_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter type reqrsp_req_t = hwpe_ctrl_reqrsp_pkg::reqrsp_req_t,
    parameter type reqrsp_rsp_t = hwpe_ctrl_reqrsp_pkg::reqrsp_rsp_t,
    localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  reqrsp_req_t   req_i [N_REQ],
    output reqrsp_rsp_t   rsp_o [N_REQ],
    output reqrsp_req_t   mst_req_o,
    input  reqrsp_rsp_t   mst_rsp_i,
    output logic          locked_o,
    output logic [OW-1:0] owner_o
);

    localparam logic [2:0]    OFF_TRIGGER = 3'd0;
    localparam logic [2:0]    OFF_SOFTCLR = 3'd3;
    localparam logic [2:0]    OFF_PUSH    = 3'd4;
    localparam logic [OW:0]   N_W         = (OW+1)'(N_REQ);
    localparam logic [OW-1:0] LAST_IDX    = OW'(N_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RSP, S_RESP} state_e;

    state_e        r_state, w_state_nxt;
    logic [OW-1:0] r_sel, w_sel_nxt;
    logic [OW-1:0] r_rr, w_rr_nxt;
    logic          r_lock, w_lock_nxt;
    logic [OW-1:0] r_owner, w_owner_nxt;
    logic [31:0]   r_buf, w_buf_nxt;

    logic [N_REQ-1:0] w_elig;
    logic [OW:0]      w_sum, w_idx;
    logic             w_found, w_hit;
    logic [OW-1:0]    w_win;
    logic [2:0]       w_off;

    // STATUS, JOBID and the unused offsets 6/7 never touch the parameter stream
    function automatic logic is_query(input logic [2:0] off);
        return (off == 3'd1) || (off == 3'd2) || (off == 3'd6) || (off == 3'd7);
    endfunction

    // Eligibility and round-robin search starting at r_rr
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        w_hit   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            w_elig[i] = req_i[i].q_valid &&
                        (!r_lock || (OW'(i) == r_owner) || is_query(req_i[i].q_addr[4:2]));
        end
        for (int k = 0; k < N_REQ; k++) begin
            w_sum   = {1'b0, r_rr} + (OW+1)'(k);
            w_idx   = (w_sum >= N_W) ? (w_sum - N_W) : w_sum;
            w_hit   = !w_found && w_elig[w_idx[OW-1:0]];
            w_win   = w_hit ? w_idx[OW-1:0] : w_win;
            w_found = w_found || w_hit;
        end
    end

    // Next-state, lock update and output steering
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_rr_nxt    = r_rr;
        w_lock_nxt  = r_lock;
        w_owner_nxt = r_owner;
        w_buf_nxt   = r_buf;
        mst_req_o   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_o[i] = '0;
        end
        w_off = req_i[r_sel].q_addr[4:2];

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_sel_nxt   = w_win;
                    w_rr_nxt    = (w_win == LAST_IDX) ? '0 : w_win + OW'(1);
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                mst_req_o               = req_i[r_sel];
                mst_req_o.p_ready       = 1'b0;
                rsp_o[r_sel].q_ready    = mst_rsp_i.q_ready;
                if (!req_i[r_sel].q_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (mst_rsp_i.q_ready && req_i[r_sel].q_write) begin
                    w_state_nxt = S_IDLE;
                    if ((w_off == OFF_PUSH) && !r_lock) begin
                        w_lock_nxt  = 1'b1;
                        w_owner_nxt = r_sel;
                    end else if (((w_off == OFF_TRIGGER) || (w_off == OFF_SOFTCLR)) &&
                                 r_lock && (r_sel == r_owner)) begin
                        w_lock_nxt = 1'b0;
                    end else begin
                        w_lock_nxt = r_lock;
                    end
                end else if (mst_rsp_i.q_ready) begin
                    w_state_nxt = S_WAIT_RSP;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_WAIT_RSP: begin
                mst_req_o.p_ready = 1'b1;
                if (mst_rsp_i.p_valid) begin
                    w_buf_nxt   = mst_rsp_i.p_data;
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT_RSP;
                end
            end
            S_RESP: begin
                rsp_o[r_sel].p_valid = 1'b1;
                rsp_o[r_sel].p_data  = r_buf;
                if (req_i[r_sel].p_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight access and drops the lock
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_rr    <= '0;
            r_lock  <= 1'b0;
            r_owner <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_rr    <= w_rr_nxt;
            r_lock  <= w_lock_nxt;
            r_owner <= w_owner_nxt;
            r_buf   <= w_buf_nxt;
        end
    end

    assign locked_o = r_lock;
    assign owner_o  = r_owner;

endmodule

// File: tb/tb_hwpe_ctrl_reqrsp_arbiter.sv
// Directed bench for hwpe_ctrl_reqrsp_arbiter: two queued requesters, an always-ready
// slave model with one-cycle read latency, and per-cycle traces checked against hand-derived values.
module tb_hwpe_ctrl_reqrsp_arbiter;
    import hwpe_ctrl_reqrsp_pkg::*;

    localparam int N = 2;

    typedef struct packed {
        logic        wr;
        logic [2:0]  off;
        logic [31:0] data;
    } op_t;

    logic          clk;
    logic          rst;
    reqrsp_req_t   req_s [N];
    reqrsp_rsp_t   rsp_s [N];
    reqrsp_req_t   mst_req_s;
    reqrsp_rsp_t   mst_rsp_s;
    logic          locked_s;
    logic [0:0]    owner_s;

    logic          slv_pv;
    logic [31:0]   slv_pd;
    logic [34:0]   wr_log [$];

    op_t           q0 [$];
    op_t           q1 [$];
    logic          pr [N];

    logic [1:0]    t_gnt  [64];
    logic [1:0]    t_pv   [64];
    logic [31:0]   t_pd0  [64];
    logic [31:0]   t_pd1  [64];
    logic [31:0]   t_mdat [64];
    logic          t_lock [64];
    logic          t_own  [64];

    int n_tests = 0;
    int n_fail  = 0;
    int lb;

    hwpe_ctrl_reqrsp_arbiter #(
        .N_REQ        (N),
        .reqrsp_req_t (reqrsp_req_t),
        .reqrsp_rsp_t (reqrsp_rsp_t)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req_s),
        .rsp_o     (rsp_s),
        .mst_req_o (mst_req_s),
        .mst_rsp_i (mst_rsp_s),
        .locked_o  (locked_s),
        .owner_o   (owner_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] slv_rdata(input logic [2:0] off);
        return (off == 3'd2) ? 32'd3 : (32'h0000_0050 + {29'd0, off});
    endfunction

    // Slave model: always ready, read data one cycle after the request handshake
    always_comb begin
        mst_rsp_s.q_ready = 1'b1;
        mst_rsp_s.p_data  = slv_pd;
        mst_rsp_s.p_valid = slv_pv;
    end

    always @(posedge clk) begin
        if (rst) begin
            slv_pv <= 1'b0;
            slv_pd <= 32'd0;
        end else begin
            slv_pv <= mst_req_s.q_valid && !mst_req_s.q_write;
            if (mst_req_s.q_valid && !mst_req_s.q_write)
                slv_pd <= slv_rdata(mst_req_s.q_addr[4:2]);
            if (mst_req_s.q_valid && mst_req_s.q_write)
                wr_log.push_back({mst_req_s.q_addr[4:2], mst_req_s.q_data});
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] log_at(input int i);
        return (i < wr_log.size()) ? wr_log[i] : 35'h7_FFFF_FFFF;
    endfunction

    function automatic op_t wop(input logic [2:0] off, input logic [31:0] data);
        return '{wr: 1'b1, off: off, data: data};
    endfunction

    function automatic op_t rop(input logic [2:0] off);
        return '{wr: 1'b0, off: off, data: 32'd0};
    endfunction

    task automatic drive_one(input int i, input logic have, input op_t op);
        req_s[i].q_valid = have;
        req_s[i].q_write = have ? op.wr : 1'b0;
        req_s[i].q_addr  = have ? {27'd0, op.off, 2'b00} : 32'd0;
        req_s[i].q_data  = have ? op.data : 32'd0;
        req_s[i].p_ready = pr[i];
    endtask

    task automatic drive();
        drive_one(0, q0.size() > 0, (q0.size() > 0) ? q0[0] : '0);
        drive_one(1, q1.size() > 0, (q1.size() > 0) ? q1[0] : '0);
    endtask

    // Runs n cycles, recording outputs at negedge and advancing queues on q handshakes
    task automatic run(input int n);
        logic hs0, hs1;
        drive();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            t_gnt[c]  = {rsp_s[1].q_ready, rsp_s[0].q_ready};
            t_pv[c]   = {rsp_s[1].p_valid, rsp_s[0].p_valid};
            t_pd0[c]  = rsp_s[0].p_data;
            t_pd1[c]  = rsp_s[1].p_data;
            t_mdat[c] = mst_req_s.q_data;
            t_lock[c] = locked_s;
            t_own[c]  = owner_s[0];
            hs0 = req_s[0].q_valid && rsp_s[0].q_ready;
            hs1 = req_s[1].q_valid && rsp_s[1].q_ready;
            @(posedge clk);
            #1;
            if (hs0) q0.delete(0);
            if (hs1) q1.delete(0);
            drive();
        end
    endtask

    initial begin
        rst   = 1'b1;
        pr[0] = 1'b1;
        pr[1] = 1'b1;
        q0.push_back(wop(3'd4, 32'h1));
        q1.push_back(wop(3'd4, 32'h2));
        drive();

        // Reset held with both requesters asserting q_valid
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rst_mqv%0d", k), mst_req_s.q_valid, 1'b0);
            chk($sformatf("rst_mpr%0d", k), mst_req_s.p_ready, 1'b0);
            chk($sformatf("rst_qr%0d", k), {rsp_s[1].q_ready, rsp_s[0].q_ready}, 2'b00);
            chk($sformatf("rst_pv%0d", k), {rsp_s[1].p_valid, rsp_s[0].p_valid}, 2'b00);
            chk($sformatf("rst_lock%0d", k), locked_s, 1'b0);
            chk($sformatf("rst_own%0d", k), owner_s, 1'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        q1.delete();

        // Round robin on STATUS writes: grants 0,1,0,1 every other cycle
        lb = wr_log.size();
        q0.push_back(wop(3'd1, 32'h100));
        q0.push_back(wop(3'd1, 32'h101));
        q1.push_back(wop(3'd1, 32'h200));
        q1.push_back(wop(3'd1, 32'h201));
        run(8);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("rr_gnt%0d", c), t_gnt[c],
                (c % 4 == 1) ? 2'b01 : ((c % 4 == 3) ? 2'b10 : 2'b00));
        end
        chk("rr_mdat1", t_mdat[1], 32'h100);
        chk("rr_mdat3", t_mdat[3], 32'h200);
        chk("rr_log0", log_at(lb + 0), {3'd1, 32'h100});
        chk("rr_log1", log_at(lb + 1), {3'd1, 32'h200});
        chk("rr_log2", log_at(lb + 2), {3'd1, 32'h101});
        chk("rr_log3", log_at(lb + 3), {3'd1, 32'h201});

        // Lock: req0 PUSH A, C, TRIGGER must finish before req1 PUSH B
        lb = wr_log.size();
        q0.push_back(wop(3'd4, 32'hA));
        q0.push_back(wop(3'd4, 32'hC));
        q0.push_back(wop(3'd0, 32'h0));
        q1.push_back(wop(3'd4, 32'hB));
        run(10);
        chk("lk_log0", log_at(lb + 0), {3'd4, 32'hA});
        chk("lk_log1", log_at(lb + 1), {3'd4, 32'hC});
        chk("lk_log2", log_at(lb + 2), {3'd0, 32'h0});
        chk("lk_log3", log_at(lb + 3), {3'd4, 32'hB});
        chk("lk_lock1", t_lock[1], 1'b0);
        chk("lk_lock2", t_lock[2], 1'b1);
        chk("lk_own2", t_own[2], 1'b0);
        chk("lk_lock5", t_lock[5], 1'b1);
        chk("lk_lock6", t_lock[6], 1'b0);
        chk("lk_gnt3", t_gnt[3], 2'b01);
        chk("lk_gnt7", t_gnt[7], 2'b10);
        chk("lk_lock8", t_lock[8], 1'b1);
        chk("lk_own8", t_own[8], 1'b1);

        // Owner SOFTCLR releases the lock; stalled req0 PUSH takes ownership
        lb = wr_log.size();
        q1.push_back(wop(3'd3, 32'h0));
        q0.push_back(wop(3'd4, 32'hD));
        run(6);
        chk("sc_gnt0", t_gnt[0], 2'b00);
        chk("sc_gnt1", t_gnt[1], 2'b10);
        chk("sc_lock1", t_lock[1], 1'b1);
        chk("sc_lock2", t_lock[2], 1'b0);
        chk("sc_gnt3", t_gnt[3], 2'b01);
        chk("sc_lock4", t_lock[4], 1'b1);
        chk("sc_own4", t_own[4], 1'b0);
        chk("sc_log0", log_at(lb + 0), {3'd3, 32'h0});
        chk("sc_log1", log_at(lb + 1), {3'd4, 32'hD});

        // Query while req0 owns the lock: req1 JOBID read proceeds, its PUSH stalls
        lb = wr_log.size();
        q1.push_back(rop(3'd2));
        q1.push_back(wop(3'd4, 32'hE));
        run(8);
        chk("qy_gnt1", t_gnt[1], 2'b10);
        chk("qy_pv2", t_pv[2], 2'b00);
        chk("qy_pv3", t_pv[3], 2'b10);
        chk("qy_pd3", t_pd1[3], 32'd3);
        for (int c = 4; c < 8; c++) begin
            chk($sformatf("qy_stall%0d", c), t_gnt[c], 2'b00);
        end
        chk("qy_nowr", wr_log.size(), lb);

        // Owner TRIGGER unblocks req1 PUSH, which then triggers its own job
        q0.push_back(wop(3'd0, 32'h0));
        q1.push_back(wop(3'd0, 32'h0));
        run(8);
        chk("tr_gnt1", t_gnt[1], 2'b01);
        chk("tr_gnt3", t_gnt[3], 2'b10);
        chk("tr_lock4", t_lock[4], 1'b1);
        chk("tr_own4", t_own[4], 1'b1);
        chk("tr_lock6", t_lock[6], 1'b0);
        chk("tr_log0", log_at(lb + 0), {3'd0, 32'h0});
        chk("tr_log1", log_at(lb + 1), {3'd4, 32'hE});
        chk("tr_log2", log_at(lb + 2), {3'd0, 32'h0});

        // Response backpressure: p_valid/p_data held, req1 waits for the handshake
        lb = wr_log.size();
        pr[0] = 1'b0;
        q0.push_back(rop(3'd1));
        q1.push_back(wop(3'd1, 32'h77));
        run(8);
        chk("bp_gnt1", t_gnt[1], 2'b01);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("bp_nogr%0d", c), t_gnt[c][1], 1'b0);
        end
        for (int c = 3; c < 8; c++) begin
            chk($sformatf("bp_pv%0d", c), t_pv[c], 2'b01);
            chk($sformatf("bp_pd%0d", c), t_pd0[c], 32'h51);
        end
        pr[0] = 1'b1;
        run(4);
        chk("bp_hs_pv", t_pv[0], 2'b01);
        chk("bp_idle", t_gnt[1], 2'b00);
        chk("bp_gnt2", t_gnt[2], 2'b10);
        chk("bp_pv1", t_pv[1], 2'b00);
        chk("bp_log0", log_at(lb + 0), {3'd1, 32'h77});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
